// File: rtl/activation_pipe.sv
// activation_pipe: two-stage valid/ready pipeline that applies one of five
// fixed-point activation functions to LANES signed elements per beat.
// Optional saturation counter enabled by defining ACTIV_SAT_COUNT_EN.
module activation_pipe #(
  parameter int N           = 16,
  parameter int FRAC        = 8,
  parameter int LANES       = 8,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [2:0]                activation_function_i,
  input  logic [LANES-1:0][N-1:0]   value_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [LANES-1:0][N-1:0]   value_o,
  input  logic                      sat_clear_i,
  output logic [31:0]               sat_count_o
);

  // ReLU6 upper bound, limited to the largest positive N-bit value.
  localparam logic [N+2:0] C6_WIDE      = (N+3)'(6) << FRAC;
  localparam logic [N+2:0] MAX_POS_WIDE = ((N+3)'(1) << (N-1)) - (N+3)'(1);
  localparam logic signed [N-1:0] C6    = (C6_WIDE > MAX_POS_WIDE) ?
                                          MAX_POS_WIDE[N-1:0] : C6_WIDE[N-1:0];
  // Hard sigmoid offset (0.5) and upper bound (1.0), one guard bit wide.
  localparam logic signed [N:0] HALF = (N+1)'(1) << (FRAC-1);
  localparam logic signed [N:0] ONE  = (N+1)'(1) << FRAC;

  logic                     s1_valid;
  logic [2:0]               s1_mode;
  logic [LANES-1:0][N-1:0]  s1_value;
  logic                     s2_load;
  logic                     in_xfer;
  logic                     out_xfer;
  logic [LANES-1:0][N-1:0]  next_value;
  logic [LANES-1:0]         next_clip;

  // One lane of the activation: returns {clip, result}.
  function automatic logic [N:0] act_lane(input logic signed [N-1:0] x,
                                          input logic [2:0] mode);
    logic signed [N-1:0] y;
    logic signed [N:0]   xe;
    logic signed [N:0]   t;
    logic                clip;
    y    = x;
    clip = 1'b0;
    xe   = {x[N-1], x};
    t    = (xe >>> 2) + HALF;
    case (mode)
      3'd1: begin
        if (x[N-1] || x == '0) y = '0;
      end
      3'd2: begin
        if (x[N-1]) y = x >>> LEAKY_SHIFT;
      end
      3'd3: begin
        if (x[N-1]) begin
          y    = '0;
          clip = 1'b1;
        end else if (x > C6) begin
          y    = C6;
          clip = 1'b1;
        end
      end
      3'd4: begin
        if (t[N]) begin
          y    = '0;
          clip = 1'b1;
        end else if (t > ONE) begin
          y    = ONE[N-1:0];
          clip = 1'b1;
        end else begin
          y    = t[N-1:0];
        end
      end
      default: y = x;
    endcase
    return {clip, y};
  endfunction

  // S2 can take S1's beat when it is empty or its own beat is leaving.
  assign s2_load  = s1_valid && (!valid_o || ready_i);
  assign ready_o  = !s1_valid || s2_load;
  assign in_xfer  = valid_i && ready_o;
  assign out_xfer = valid_o && ready_i;

  // Evaluate the selected activation on every lane of the S1 beat.
  always_comb begin
    logic [N:0] r;
    next_value = '0;
    next_clip  = '0;
    r          = '0;
    for (int l = 0; l < LANES; l++) begin
      r             = act_lane(s1_value[l], s1_mode);
      next_value[l] = r[N-1:0];
      next_clip[l]  = r[N];
    end
  end

  // Stage 1: capture the incoming beat and its mode, or empty when it moves on.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_mode  <= '0;
      s1_value <= '0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_mode  <= activation_function_i;
      s1_value <= value_i;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: register results; hold them while downstream stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      value_o <= '0;
    end else if (s2_load) begin
      valid_o <= 1'b1;
      value_o <= next_value;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

`ifdef ACTIV_SAT_COUNT_EN
  logic [LANES-1:0] s2_clip;
  logic [31:0]      clip_sum;
  logic [32:0]      sat_sum;

  // Clip flags travel alongside the S2 result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_clip <= '0;
    end else if (s2_load) begin
      s2_clip <= next_clip;
    end
  end

  // Number of clipped lanes in the beat currently at the output.
  always_comb begin
    clip_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      clip_sum = clip_sum + 32'(s2_clip[l]);
    end
  end

  assign sat_sum = {1'b0, sat_count_o} + {1'b0, clip_sum};

  // Saturating counter of clipped lanes; a clear beats a same-cycle increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sat_count_o <= '0;
    end else if (sat_clear_i) begin
      sat_count_o <= '0;
    end else if (out_xfer) begin
      sat_count_o <= sat_sum[32] ? '1 : sat_sum[31:0];
    end
  end
`else
  logic unused_signals;
  assign unused_signals = ^{sat_clear_i, next_clip, out_xfer};
  assign sat_count_o    = '0;
`endif

endmodule
